// File: rtl/door_input_cond_if.sv
// Signal bundle between the raw door inputs and the door-control FSM inputs.
// master drives the raw switches; slave (the conditioner) returns clean levels.
interface door_input_cond_if;
  logic Btn_Raw;
  logic Up_Sw_Raw;
  logic Down_Sw_Raw;
  logic Activate;
  logic Up_Max;
  logic Down_Max;

  modport master (
    output Btn_Raw, Up_Sw_Raw, Down_Sw_Raw,
    input  Activate, Up_Max, Down_Max
  );

  modport slave (
    input  Btn_Raw, Up_Sw_Raw, Down_Sw_Raw,
    output Activate, Up_Max, Down_Max
  );
endinterface

// File: rtl/door_input_cond.sv
// Synchronize and debounce the door push-button and limit switches; the button yields a one-cycle Activate.
// Optional macro DB_LOCKOUT_EN adds an Activate holdoff of LOCKOUT_CYCLES after each pulse.
module door_input_cond #(
  parameter int DB_COUNT       = 10,
  parameter int CNT_W          = 4,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int LK_W           = 5
) (
  input logic CLK,
  input logic RST,
  door_input_cond_if.slave io
);

  if (DB_COUNT < 1 || DB_COUNT > (1 << CNT_W)) begin : g_db_range
    $error("DB_COUNT out of range for CNT_W");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > (1 << LK_W) - 1) begin : g_lk_range
    $error("LOCKOUT_CYCLES out of range for LK_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  // Channel index: 0 = button, 1 = upper limit, 2 = lower limit.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       accept;
  logic             btn_rise;
  logic             fire;
  logic             activate;

  assign raw = {io.Down_Sw_Raw, io.Up_Sw_Raw, io.Btn_Raw};

  always_comb begin
    accept = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign btn_rise = accept[0] && s2[0];

`ifdef DB_LOCKOUT_EN
  logic [LK_W-1:0] lk_cnt;

  // A counter value of 1 means it reaches 0 on this edge, so a press is allowed.
  assign fire = btn_rise && (lk_cnt <= LK_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      lk_cnt <= '0;
    end else if (fire) begin
      lk_cnt <= LK_W'(LOCKOUT_CYCLES);
    end else if (lk_cnt != '0) begin
      lk_cnt <= lk_cnt - LK_W'(1);
    end
  end
`else
  assign fire = btn_rise;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      activate <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= raw;
      s2       <= s1;
      activate <= fire;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign io.Activate = activate;
  assign io.Up_Max   = stable[1];
  assign io.Down_Max = stable[2];

endmodule
